// File: rtl/uart_rx_to_mem.sv
// uart_rx_to_mem: 8N1 UART receiver that writes arriving bytes, in order, into a ROW*COLUMN matrix memory.
module uart_rx_to_mem #(
  parameter int ROW          = 2,
  parameter int COLUMN       = 2,
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_data,
  input  logic        load_start,
  output logic        write,
  output logic [31:0] write_address,
  output logic [7:0]  write_value,
  output logic        busy,
  output logic        load_done,
  output logic        frame_err,
  output logic [31:0] values_rcvd_count
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0] LAST = 32'(ROW * COLUMN - 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_BREAK} rx_state_t;
  typedef enum logic [1:0] {L_IDLE, L_RECV, L_DONE} ld_state_t;

  rx_state_t   rx_q;
  ld_state_t   ld_q;
  logic [1:0]  sync_q;
  logic [CW-1:0] clk_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        ls_q;
  logic        rx_s, byte_valid, stop_err, ls_edge;

  always_comb begin
    rx_s       = sync_q[1];
    byte_valid = (rx_q == R_STOP) && (clk_cnt_q == FULL) && rx_s;
    stop_err   = (rx_q == R_STOP) && (clk_cnt_q == FULL) && !rx_s;
    ls_edge    = load_start && !ls_q;
  end

  // Samples land mid-bit: half a bit after the falling start edge, then every full bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= 2'b11;
      rx_q      <= R_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      sync_q    <= {sync_q[0], rx_data};
      clk_cnt_q <= clk_cnt_q + 1'b1;
      case (rx_q)
        R_IDLE: begin
          clk_cnt_q <= '0;
          if (!rx_s) rx_q <= R_START;
        end
        R_START: if (clk_cnt_q == HALF) begin
          clk_cnt_q <= '0;
          bit_cnt_q <= '0;
          rx_q      <= rx_s ? R_IDLE : R_DATA;
        end
        R_DATA: if (clk_cnt_q == FULL) begin
          clk_cnt_q <= '0;
          shift_q   <= {rx_s, shift_q[7:1]};
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) rx_q <= R_STOP;
        end
        R_STOP:  if (clk_cnt_q == FULL) rx_q <= rx_s ? R_IDLE : R_BREAK;
        R_BREAK: if (rx_s) rx_q <= R_IDLE;
        default: rx_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_q              <= L_IDLE;
      ls_q              <= 1'b0;
      write             <= 1'b0;
      write_address     <= '0;
      write_value       <= '0;
      busy              <= 1'b0;
      load_done         <= 1'b0;
      frame_err         <= 1'b0;
      values_rcvd_count <= '0;
    end else begin
      ls_q      <= load_start;
      write     <= 1'b0;
      load_done <= 1'b0;
      if (stop_err && busy) frame_err <= 1'b1;
      case (ld_q)
        L_IDLE: if (ls_edge) begin
          ld_q              <= L_RECV;
          values_rcvd_count <= '0;
          frame_err         <= 1'b0;
          busy              <= 1'b1;
        end
        L_RECV: if (byte_valid) begin
          write             <= 1'b1;
          write_address     <= values_rcvd_count;
          write_value       <= shift_q;
          values_rcvd_count <= values_rcvd_count + 32'd1;
          if (values_rcvd_count == LAST) ld_q <= L_DONE;
        end
        L_DONE: begin
          load_done <= 1'b1;
          busy      <= 1'b0;
          ld_q      <= L_IDLE;
        end
        default: ld_q <= L_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_to_mem.sv
// tb_uart_rx_to_mem: table-driven UART load tests with a write scoreboard and a few hand-written corner sequences.
module tb_uart_rx_to_mem;
  localparam int CPB = 16;

  logic        clk = 1'b0, rst = 1'b1, rx_data = 1'b1, load_start = 1'b0;
  logic        write, busy, load_done, frame_err;
  logic [31:0] write_address, values_rcvd_count;
  logic [7:0]  write_value;

  uart_rx_to_mem #(.ROW(2), .COLUMN(2), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .load_start(load_start),
    .write(write), .write_address(write_address), .write_value(write_value),
    .busy(busy), .load_done(load_done), .frame_err(frame_err),
    .values_rcvd_count(values_rcvd_count)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic [7:0] val;} wr_t;
  typedef struct {bit arm; logic [7:0] data; bit good; bit exp_wr; logic [31:0] exp_addr;} vec_t;

  wr_t sb[$];
  int errors = 0, checks = 0, cyc = 0, last_wr = -10, done_cnt = 0;
  int mcnt = 0, mdone = 0;
  bit mbusy = 0, mfe = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      if (write) begin
        check("write_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("write_addr", write_address, e.addr);
          check("write_value", 32'(write_value), 32'(e.val));
        end
        last_wr = cyc;
      end
      if (load_done) begin
        done_cnt++;
        check("done_latency", cyc, last_wr + 1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    rx_data = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_data = b[i];
      tick(CPB);
    end
    rx_data = good;
    tick(CPB);
    rx_data = 1'b1;
    tick(good ? 2 : CPB);
  endtask

  task automatic arm();
    load_start = 1'b1;
    tick(2);
    load_start = 1'b0;
    tick(2);
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good);
    if (good && mbusy) sb.push_back('{32'(mcnt), b});
    send_byte(b, good);
    if (!good && mbusy) mfe = 1;
    if (good && mbusy) begin
      mcnt++;
      if (mcnt == 4) begin
        mbusy = 0;
        mdone++;
      end
    end
  endtask

  task automatic model_arm();
    arm();
    if (!mbusy) begin
      mcnt = 0;
      mbusy = 1;
      mfe = 0;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, values_rcvd_count, 32'(mcnt));
    check({tag, "_busy"}, 32'(busy), 32'(mbusy));
    check({tag, "_frame_err"}, 32'(frame_err), 32'(mfe));
    check({tag, "_done_cnt"}, done_cnt, mdone);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_write"}, 32'(write), 32'd0);
    check({tag, "_addr"}, write_address, 32'd0);
    check({tag, "_value"}, 32'(write_value), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(load_done), 32'd0);
    check({tag, "_ferr"}, 32'(frame_err), 32'd0);
    check({tag, "_count"}, values_rcvd_count, 32'd0);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{0, 8'hA5, 1, 0, 0};
    vecs[1] = '{1, 8'h11, 1, 1, 0};
    vecs[2] = '{0, 8'h22, 1, 1, 1};
    vecs[3] = '{0, 8'h33, 1, 1, 2};
    vecs[4] = '{0, 8'h44, 1, 1, 3};
    vecs[5] = '{1, 8'h01, 1, 1, 0};
    vecs[6] = '{0, 8'hFF, 0, 0, 0};
    vecs[7] = '{0, 8'h02, 1, 1, 1};
    vecs[8] = '{0, 8'h03, 1, 1, 2};
    vecs[9] = '{0, 8'h04, 1, 1, 3};

    tick(3);
    check_zero("reset");
    rst = 1'b0;
    tick(5);

    foreach (vecs[k]) begin
      if (vecs[k].arm) begin
        arm();
        mcnt = 0;
        mbusy = 1;
        mfe = 0;
      end
      if (vecs[k].exp_wr) sb.push_back('{vecs[k].exp_addr, vecs[k].data});
      send_byte(vecs[k].data, vecs[k].good);
      if (!vecs[k].good && mbusy) mfe = 1;
      if (vecs[k].exp_wr) begin
        mcnt = vecs[k].exp_addr + 1;
        if (mcnt == 4) begin
          mbusy = 0;
          mdone++;
        end
      end
      check_state($sformatf("vec%0d", k));
    end

    // Short low glitch must be rejected; the receiver then still takes a full load.
    model_arm();
    rx_data = 1'b0;
    tick(4);
    rx_data = 1'b1;
    tick(3 * CPB);
    check_state("glitch");
    model_byte(8'h5A, 1);
    model_byte(8'hC3, 1);
    model_byte(8'h0F, 1);
    model_byte(8'hF0, 1);
    check_state("after_glitch");

    // Reset in the middle of the second byte abandons the load.
    model_arm();
    model_byte(8'h77, 1);
    check_state("pre_rst");
    rx_data = 1'b0;
    tick(CPB);
    rx_data = 1'b1;
    tick(CPB / 2);
    rst = 1'b1;
    tick(2);
    check_zero("mid_rst");
    rst = 1'b0;
    mcnt = 0;
    mbusy = 0;
    mfe = 0;
    tick(2 * CPB);
    check_state("post_rst");
    model_arm();
    model_byte(8'h9C, 1);
    model_byte(8'h3E, 1);
    model_byte(8'h81, 1);
    model_byte(8'h6D, 1);
    check_state("rearm");

    // A second arm edge mid-load is ignored.
    model_arm();
    model_byte(8'hAA, 1);
    model_byte(8'hBB, 1);
    model_arm();
    check_state("second_edge");
    model_byte(8'hCC, 1);
    model_byte(8'hDD, 1);
    tick(4);
    check_state("single_done");

    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
